gmii_tx_sender: RTL and testbench



---
 rtl/gmii_tx_sender_pkg.sv | 16 +
 rtl/gmii_tx_sender_crc.sv | 19 +
 rtl/gmii_tx_sender.sv | 121 ++++++++++++
 tb/tb_gmii_tx_sender.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/gmii_tx_sender_pkg.sv
// gmii_tx_sender_pkg: shared states, framing constants and CRC-32 byte step
package gmii_tx_sender_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG} state_t;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
        return r;
    endfunction
endpackage

// File: rtl/gmii_tx_sender_crc.sv
// crc32_d8: reflected Ethernet CRC-32, one byte per cycle, LSB of d first
module crc32_d8
    import gmii_tx_sender_pkg::*;
(
    input  logic        tx_clk,
    input  logic        sys_rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);
    always_ff @(posedge tx_clk or negedge sys_rst_n)
        if (!sys_rst_n)
            crc <= CRC_INIT;
        else if (init)
            crc <= CRC_INIT;
        else if (en)
            crc <= crc32_byte(crc, d);
endmodule

// File: rtl/gmii_tx_sender.sv
// gmii_tx_sender: drains 24-bit FIFO words into fixed-length Ethernet II frames on GMII
module gmii_tx_sender
    import gmii_tx_sender_pkg::*;
#(
    parameter logic [47:0] DST_MAC = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC = 48'h00_0A_35_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int PAYLOAD_WORDS = 16,
    parameter int IFG_CYCLES = 12
) (
    input  logic        tx_clk,
    input  logic        sys_rst_n,
    input  logic [23:0] dout,
    input  logic        empty,
    input  logic        full,
    output logic        rd_en,
    output logic        tx_en,
    output logic [7:0]  txd
);
    localparam int PLEN = 3 * PAYLOAD_WORDS;
    localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};
    state_t state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [1:0] bsel, bsel_nx;
    logic [15:0] hold;
    logic rd_d;
    logic [31:0] crc, fcs;
    logic [6:0] hsh;
    logic [4:0] fsh;
    logic unused;
    assign unused = full;
    always_ff @(posedge tx_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt <= '0;
            bsel <= '0;
            hold <= '0;
            rd_d <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            bsel <= bsel_nx;
            rd_d <= rd_en;
            if (state == PAYLOAD && bsel == 2'd0)
                hold <= rd_d ? dout[15:0] : '0;
        end
    // in IDLE, cnt[0] records that empty was seen low; the frame starts one edge later
    always_comb begin
        state_nx = state;
        cnt_nx = cnt + 16'd1;
        bsel_nx = bsel;
        case (state)
            IDLE: begin
                cnt_nx = {15'd0, !empty};
                if (cnt[0]) begin
                    state_nx = PREAMBLE;
                    cnt_nx = '0;
                end
            end
            PREAMBLE: if (cnt == 16'd6) begin
                state_nx = SFD;
                cnt_nx = '0;
            end
            SFD: begin
                state_nx = HEADER;
                cnt_nx = '0;
            end
            HEADER: if (cnt == 16'd13) begin
                state_nx = PAYLOAD;
                cnt_nx = '0;
                bsel_nx = '0;
            end
            PAYLOAD: begin
                bsel_nx = bsel == 2'd2 ? 2'd0 : bsel + 2'd1;
                if (cnt == 16'(PLEN - 1)) begin
                    state_nx = FCS;
                    cnt_nx = '0;
                end
            end
            FCS: if (cnt == 16'd3) begin
                state_nx = IFG;
                cnt_nx = '0;
            end
            IFG: if (cnt == 16'(IFG_CYCLES - 1)) begin
                state_nx = IDLE;
                cnt_nx = {15'd0, !empty};
            end
            default: begin
                state_nx = IDLE;
                cnt_nx = '0;
            end
        endcase
    end
    assign tx_en = state != IDLE && state != IFG;
    assign rd_en = !empty && ((state == HEADER && cnt == 16'd13) ||
                              (state == PAYLOAD && bsel == 2'd2 && cnt != 16'(PLEN - 1)));
    assign fcs = ~crc;
    assign hsh = {4'd13 - cnt[3:0], 3'b000};
    assign fsh = {cnt[1:0], 3'b000};
    // first byte of each word comes straight from the FIFO; an underrun word reads as zero
    always_comb begin
        txd = 8'h00;
        case (state)
            PREAMBLE: txd = PREAMBLE_BYTE;
            SFD:      txd = SFD_BYTE;
            HEADER:   txd = HDR[hsh +: 8];
            PAYLOAD:  txd = bsel == 2'd0 ? (rd_d ? dout[23:16] : 8'h00) :
                            bsel == 2'd1 ? hold[15:8] : hold[7:0];
            FCS:      txd = fcs[fsh +: 8];
            default:  txd = 8'h00;
        endcase
    end
    crc32_d8 u_crc (
        .tx_clk(tx_clk),
        .sys_rst_n(sys_rst_n),
        .init(state == SFD),
        .en(state == HEADER || state == PAYLOAD),
        .d(txd),
        .crc(crc)
    );
endmodule

// File: tb/tb_gmii_tx_sender.sv
// tb_gmii_tx_sender: directed frame, underrun, idle and mid-frame reset checks
module tb_gmii_tx_sender;
    logic tx_clk = 1'b0;
    logic sys_rst_n, empty, full, rd_en, tx_en;
    logic [23:0] dout;
    logic [7:0] txd;
    int ncmp = 0, nerr = 0, nrd = 0, viol = 0;
    logic [23:0] word = 24'd1;
    logic [23:0] rd_last;
    logic [7:0] fr [200];
    logic [7:0] hdr_b [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01, 8'h88, 8'hB5};
    always #4 tx_clk = ~tx_clk;
    gmii_tx_sender dut (
        .tx_clk(tx_clk),
        .sys_rst_n(sys_rst_n),
        .dout(dout),
        .empty(empty),
        .full(full),
        .rd_en(rd_en),
        .tx_en(tx_en),
        .txd(txd)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        bit fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction
    task automatic cyc();
        bit r;
        r = rd_en;
        if (r && empty) viol++;
        if (r) nrd++;
        @(posedge tx_clk);
        #1;
        if (r) begin
            dout = word;
            word++;
            if (word > rd_last) empty = 1'b1;
        end
        @(negedge tx_clk);
    endtask
    task automatic get_frame(output int len, output int rds, output int gap, output logic [23:0] base);
        int r0;
        gap = 0;
        while (!tx_en && gap < 400) begin
            cyc();
            gap++;
        end
        base = word;
        r0 = nrd;
        len = 0;
        while (tx_en && len < 200) begin
            fr[len] = txd;
            len++;
            cyc();
        end
        rds = nrd - r0;
    endtask
    task automatic check_frame(input string tag, input logic [23:0] base, input int navail, input int len);
        logic [7:0] e [74];
        logic [31:0] c, r;
        logic [23:0] w;
        chk({tag, " len"}, len, 74);
        for (int i = 0; i < 7; i++) e[i] = 8'h55;
        e[7] = 8'hD5;
        for (int i = 0; i < 14; i++) e[8 + i] = hdr_b[i];
        for (int k = 0; k < 48; k++) begin
            w = (k / 3 < navail) ? base + 24'(k / 3) : 24'h0;
            e[22 + k] = 8'(w >> (16 - 8 * (k % 3)));
        end
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 70; i++) c = crc_upd(c, e[i]);
        for (int j = 0; j < 4; j++) e[70 + j] = 8'(~c >> (8 * j));
        for (int i = 0; i < 74; i++) chk($sformatf("%s byte%0d", tag, i), fr[i], e[i]);
        r = 32'hFFFFFFFF;
        for (int i = 8; i < 74; i++) r = crc_upd(r, fr[i]);
        chk({tag, " residue"}, r, 32'hDEBB20E3);
    endtask
    initial begin
        int len, rds, gap, t, n0;
        logic [23:0] base;
        sys_rst_n = 1'b0;
        empty = 1'b0;
        full = 1'b0;
        dout = 24'h0;
        rd_last = '1;
        @(negedge tx_clk);
        repeat (3) begin
            cyc();
            chk("rst tx_en", tx_en, 0);
            chk("rst txd", txd, 0);
            chk("rst rd_en", rd_en, 0);
        end
        sys_rst_n = 1'b1;
        get_frame(len, rds, gap, base);
        chk("f1 start", gap, 2);
        chk("f1 rds", rds, 16);
        chk("f1 base", base, 24'd1);
        check_frame("f1", base, 16, len);
        get_frame(len, rds, gap, base);
        chk("f2 gap", gap, 13);
        chk("f2 rds", rds, 16);
        check_frame("f2", base, 16, len);
        rd_last = word + 24'd4;
        get_frame(len, rds, gap, base);
        chk("f3 gap", gap, 13);
        chk("f3 rds", rds, 5);
        check_frame("f3", base, 5, len);
        n0 = nrd;
        t = 0;
        repeat (300) begin
            cyc();
            if (tx_en) t++;
        end
        chk("idle tx_en", t, 0);
        chk("idle rds", nrd - n0, 0);
        empty = 1'b0;
        rd_last = '1;
        t = 0;
        while (!tx_en && t < 10) begin
            cyc();
            t++;
        end
        chk("f4 start", tx_en, 1);
        repeat (35) cyc();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("abort tx_en", tx_en, 0);
        chk("abort txd", txd, 0);
        cyc();
        cyc();
        sys_rst_n = 1'b1;
        get_frame(len, rds, gap, base);
        chk("f5 start", gap, 2);
        chk("f5 rds", rds, 16);
        check_frame("f5", base, 16, len);
        chk("rd while empty", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
